// File: rtl/riscv_irq_arbiter.sv
// Purpose : collects up to 32 level/edge interrupt lines into a pending register,
//           picks one winner by fixed priority and holds it as a single request.
// Latency : line asserted before edge k -> pending after k -> irq_o after k+1.
// Backpressure: the request is held until irq_ack_i or irq_kill_i. A higher
//           priority line does not preempt it. After an ack there is one dead
//           cycle, so at most one grant is made every 3 cycles.
//
// Optional feature: define RISCV_IRQ_ARB_SEC_PRIO_EN so that pending secure
// lines always beat non-secure ones. Without it, the secure bit is only
// carried through to irq_sec_o.
//
// Ports:
//   clk, rst_n        core clock; async active-low reset
//   irq_lines_i       raw interrupt lines
//   irq_edge_mode_i   per line: 1 = rising-edge, 0 = level
//   irq_mask_i        per-line enable (0 also clears pending)
//   irq_sec_lines_i   per-line secure attribute
//   irq_o/irq_id_o/irq_sec_o  registered request to the interrupt controller
//   irq_ack_i/irq_kill_i      controller accept / drop (only honoured in REQ)
//   pending_o         pending register for CSR readback
module riscv_irq_arbiter #(
    parameter int N_IRQ = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] irq_lines_i,
    input  logic [31:0] irq_edge_mode_i,
    input  logic [31:0] irq_mask_i,
    input  logic [31:0] irq_sec_lines_i,
    output logic        irq_o,
    output logic [4:0]  irq_id_o,
    output logic        irq_sec_o,
    input  logic        irq_ack_i,
    input  logic        irq_kill_i,
    output logic [31:0] pending_o
);

    // Lines at or above N_IRQ are tied inactive.
    localparam logic [31:0] IMPL_MASK = (N_IRQ >= 32) ? 32'hFFFF_FFFF
                                      : ((32'h1 << N_IRQ) - 32'h1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_line_q;
    logic [31:0] r_pend;
    logic [4:0]  r_id;
    logic        r_sec;
    logic        r_irq;

    logic [31:0] w_lines;
    logic [31:0] w_mask;
    logic [31:0] w_edge_set;
    logic [31:0] w_ack_clr;
    logic [31:0] w_pend_edge;
    logic [31:0] w_pend_lvl;
    logic [31:0] w_pend_nxt;
    logic [4:0]  w_win_id;
    logic        w_latch;
    logic        w_ack_fire;

    // Highest set index of a 32-bit vector (0 when empty).
    function automatic logic [4:0] f_highest(input logic [31:0] v);
        logic [4:0] id;
        id = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) id = 5'(i);
        end
        return id;
    endfunction

    assign w_lines = irq_lines_i & IMPL_MASK;
    assign w_mask  = irq_mask_i  & IMPL_MASK;

    // ------------------------------------------------------------------
    // Arbitration on the registered pending vector
    // ------------------------------------------------------------------
`ifdef RISCV_IRQ_ARB_SEC_PRIO_EN
    logic [31:0] w_sec_pend;
    assign w_sec_pend = r_pend & irq_sec_lines_i;
    assign w_win_id   = (|w_sec_pend) ? f_highest(w_sec_pend) : f_highest(r_pend);
`else
    assign w_win_id   = f_highest(r_pend);
`endif

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_ack_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack beats kill; kill beats withdrawal.
                if (irq_ack_i) begin
                    w_ack_fire  = 1'b1;
                    w_state_nxt = ST_ACK;
                end else if (irq_kill_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (!r_pend[r_id]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pending update
    // ------------------------------------------------------------------
    assign w_edge_set  = w_lines & ~r_line_q & w_mask;
    assign w_ack_clr   = w_ack_fire ? (32'h1 << r_id) : 32'h0;
    // The new edge is ORed in after the ack clear, so a set in the same
    // cycle as the ack survives.
    assign w_pend_edge = (r_pend & ~w_ack_clr & w_mask) | w_edge_set;
    assign w_pend_lvl  = w_lines & w_mask;
    assign w_pend_nxt  = ((irq_edge_mode_i & w_pend_edge) |
                          (~irq_edge_mode_i & w_pend_lvl)) & IMPL_MASK;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_line_q <= '0;
            r_pend   <= '0;
            r_id     <= '0;
            r_sec    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_line_q <= w_lines;
            r_pend   <= w_pend_nxt;
            r_irq    <= (w_state_nxt == ST_REQ);
            if (w_latch) begin
                r_id  <= w_win_id;
                r_sec <= irq_sec_lines_i[w_win_id];
            end else if (w_ack_fire) begin
                r_sec <= 1'b0;
            end
        end
    end

    assign irq_o     = r_irq;
    assign irq_id_o  = r_id;
    assign irq_sec_o = r_sec;
    assign pending_o = r_pend;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Purpose : directed self-checking bench for riscv_irq_arbiter.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: ack/kill driven directly by the scenario tasks.
module tb_riscv_irq_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq_lines_i;
    logic [31:0] irq_edge_mode_i;
    logic [31:0] irq_mask_i;
    logic [31:0] irq_sec_lines_i;
    logic        irq_o;
    logic [4:0]  irq_id_o;
    logic        irq_sec_o;
    logic        irq_ack_i;
    logic        irq_kill_i;
    logic [31:0] pending_o;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_irq_arbiter #(.N_IRQ(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_lines_i     (irq_lines_i),
        .irq_edge_mode_i (irq_edge_mode_i),
        .irq_mask_i      (irq_mask_i),
        .irq_sec_lines_i (irq_sec_lines_i),
        .irq_o           (irq_o),
        .irq_id_o        (irq_id_o),
        .irq_sec_o       (irq_sec_o),
        .irq_ack_i       (irq_ack_i),
        .irq_kill_i      (irq_kill_i),
        .pending_o       (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        irq_lines_i     = '0;
        irq_edge_mode_i = '0;
        irq_mask_i      = 32'hFFFF_FFFF;
        irq_sec_lines_i = '0;
        irq_ack_i       = 1'b0;
        irq_kill_i      = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        irq_lines_i     = 32'hFFFF_FFFF;
        irq_edge_mode_i = '0;
        irq_mask_i      = 32'hFFFF_FFFF;
        irq_sec_lines_i = 32'hFFFF_FFFF;
        irq_ack_i       = 1'b0;
        irq_kill_i      = 1'b0;
        step(2);
        n_checks++;
        if ({irq_o, irq_id_o, irq_sec_o} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_out irq=%b id=%0d sec=%b exp 0/0/0", irq_o, irq_id_o, irq_sec_o);
        end
        n_checks++;
        if (pending_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pend got=%h exp=00000000", pending_o);
        end
    endtask

    // Level line 11: request, ack, re-issue after 3 cycles, then drop.
    task automatic test_level();
        do_reset();
        irq_sec_lines_i = 32'h0000_0800;
        irq_lines_i     = 32'h0000_0800;
        step(1);
        n_checks++;
        if (pending_o !== 32'h0000_0800 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lvl_pend pend=%h irq=%b exp 00000800/0", pending_o, irq_o);
        end
        step(1);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd11 || irq_sec_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lvl_req irq=%b id=%0d sec=%b exp 1/11/1", irq_o, irq_id_o, irq_sec_o);
        end
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        n_checks++;
        if (irq_o !== 1'b0 || irq_sec_o !== 1'b0 || irq_id_o !== 5'd11) begin
            n_fail++;
            $display("FAIL lvl_ack irq=%b sec=%b id=%0d exp 0/0/11", irq_o, irq_sec_o, irq_id_o);
        end
        step(1);
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lvl_idle irq=%b exp=0", irq_o);
        end
        step(1);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd11) begin
            n_fail++;
            $display("FAIL lvl_reissue irq=%b id=%0d exp 1/11", irq_o, irq_id_o);
        end
        irq_lines_i = '0;
        irq_ack_i   = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        step(2);
        n_checks++;
        if (irq_o !== 1'b0 || pending_o !== 32'h0) begin
            n_fail++;
            $display("FAIL lvl_quiet irq=%b pend=%h exp 0/00000000", irq_o, pending_o);
        end
    endtask

    // Edge lines 3 and 20 pulse together: grant 20, then 3, then nothing.
    task automatic test_edge_pair();
        do_reset();
        irq_edge_mode_i = 32'hFFFF_FFFF;
        irq_lines_i     = 32'h0010_0008;
        step(1);
        irq_lines_i = '0;
        n_checks++;
        if (pending_o !== 32'h0010_0008) begin
            n_fail++;
            $display("FAIL edge_pend got=%h exp=00100008", pending_o);
        end
        step(1);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd20) begin
            n_fail++;
            $display("FAIL edge_grant20 irq=%b id=%0d exp 1/20", irq_o, irq_id_o);
        end
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        n_checks++;
        if (pending_o !== 32'h0000_0008 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_clr20 pend=%h irq=%b exp 00000008/0", pending_o, irq_o);
        end
        step(2);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd3) begin
            n_fail++;
            $display("FAIL edge_grant3 irq=%b id=%0d exp 1/3", irq_o, irq_id_o);
        end
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        step(2);
        n_checks++;
        if (pending_o !== 32'h0 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_empty pend=%h irq=%b exp 00000000/0", pending_o, irq_o);
        end
    endtask

    // Line 7 in REQ, then masked: pending clears, request withdrawn.
    task automatic test_mask_withdraw();
        do_reset();
        irq_lines_i = 32'h0000_0080;
        step(2);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd7) begin
            n_fail++;
            $display("FAIL mask_req irq=%b id=%0d exp 1/7", irq_o, irq_id_o);
        end
        irq_mask_i = 32'hFFFF_FF7F;
        step(1);
        n_checks++;
        if (pending_o[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_pend7 got=%b exp=0", pending_o[7]);
        end
        step(1);
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_drop irq=%b exp=0", irq_o);
        end
        step(2);
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_stay irq=%b exp=0", irq_o);
        end
    endtask

    // Line 16: kill keeps pending and re-issues; ack+kill acts as ack.
    task automatic test_kill();
        do_reset();
        irq_lines_i = 32'h0001_0000;
        step(2);
        irq_kill_i = 1'b1;
        step(1);
        irq_kill_i = 1'b0;
        n_checks++;
        if (irq_o !== 1'b0 || pending_o[16] !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_drop irq=%b pend16=%b exp 0/1", irq_o, pending_o[16]);
        end
        step(1);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd16) begin
            n_fail++;
            $display("FAIL kill_reissue irq=%b id=%0d exp 1/16", irq_o, irq_id_o);
        end
        irq_ack_i  = 1'b1;
        irq_kill_i = 1'b1;
        step(1);
        irq_ack_i  = 1'b0;
        irq_kill_i = 1'b0;
        step(1);
        // Kill would have re-requested here; ack still has its dead cycle.
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ackkill_dead irq=%b exp=0", irq_o);
        end
        step(1);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd16) begin
            n_fail++;
            $display("FAIL ackkill_next irq=%b id=%0d exp 1/16", irq_o, irq_id_o);
        end
    endtask

    // Edge line 25 acked on the same edge as a new rising edge.
    task automatic test_ack_vs_edge();
        do_reset();
        irq_edge_mode_i = 32'h0200_0000;
        irq_lines_i     = 32'h0200_0000;
        step(1);
        irq_lines_i = '0;
        step(1);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd25) begin
            n_fail++;
            $display("FAIL e25_req irq=%b id=%0d exp 1/25", irq_o, irq_id_o);
        end
        irq_lines_i = 32'h0200_0000;
        irq_ack_i   = 1'b1;
        step(1);
        irq_ack_i   = 1'b0;
        irq_lines_i = '0;
        n_checks++;
        if (pending_o[25] !== 1'b1 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL e25_setwins pend25=%b irq=%b exp 1/0", pending_o[25], irq_o);
        end
        step(2);
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd25) begin
            n_fail++;
            $display("FAIL e25_regrant irq=%b id=%0d exp 1/25", irq_o, irq_id_o);
        end
    endtask

    // Secure line 5 vs non-secure line 30.
    task automatic test_sec_prio();
        do_reset();
        irq_sec_lines_i = 32'h0000_0020;
        irq_lines_i     = 32'h4000_0020;
        step(2);
`ifdef RISCV_IRQ_ARB_SEC_PRIO_EN
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd5 || irq_sec_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sec_grant irq=%b id=%0d sec=%b exp 1/5/1", irq_o, irq_id_o, irq_sec_o);
        end
`else
        n_checks++;
        if (irq_o !== 1'b1 || irq_id_o !== 5'd30 || irq_sec_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sec_grant irq=%b id=%0d sec=%b exp 1/30/0", irq_o, irq_id_o, irq_sec_o);
        end
`endif
    endtask

    // Asynchronous reset asserted while a request is outstanding.
    task automatic test_reset_mid_req();
        do_reset();
        irq_sec_lines_i = 32'h0000_0800;
        irq_lines_i     = 32'h0000_0800;
        step(2);
        n_checks++;
        if (irq_o !== 1'b1 || irq_sec_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_req irq=%b sec=%b exp 1/1", irq_o, irq_sec_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({irq_o, irq_id_o, irq_sec_o} !== 7'd0 || pending_o !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset irq=%b id=%0d sec=%b pend=%h exp all 0",
                     irq_o, irq_id_o, irq_sec_o, pending_o);
        end
        step(1);
        do_reset();
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge_pair();
        test_mask_withdraw();
        test_kill();
        test_ack_vs_edge();
        test_sec_prio();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
